rx_word_loader: RTL and testbench
=================================

// Module: rx_word_loader
// PURPOSE
// Upstream loader for the mips/mem top: collects 8-bit rx_data bytes, assembles them into
// N-bit little-endian words and writes each word into memory over a req/ack handshake.
// Drives the top's rx_check/rx_checkh/rx_checkl status outputs.
// A zero-padded flush after an idle timeout loads programs whose length is not a word multiple.
// PARAMETERS
// N        64    data word width; must be a multiple of 8 (BYTES = N/8)
// ADRW     8     word-address width; address wraps modulo 2**ADRW
// TIMEOUT  1024  idle cycles after the last byte before a partial word is flushed (>=2)
// PORTS
// clk        in   1      rising-edge clock
// reset      in   1      asynchronous, active-low reset
// rx_valid   in   1      one-cycle strobe: rx_data holds a new byte
// rx_data    in   8      received byte
// rx_clear   in   1      sync restart: drop partial word and pending write, zero address/count
// wr_req     out  1      write request to memory; held until wr_ack
// wr_adr     out  ADRW   word address of pending write
// wr_data    out  N      pending word
// wr_ack     in   1      memory accepted write (sampled only while wr_req=1)
// overflow   out  1      sticky: a completed word was dropped
// rx_check   out  32     number of words acknowledged since reset/clear
// rx_checkh  out  32     wr_data[N-1:32] of last acknowledged word (zero-extended if N<64)
// rx_checkl  out  32     wr_data[31:0] of last acknowledged word
// BEHAVIOUR
// - Reset (reset=0, async): all outputs 0, byte counter 0, timer 0, assembly reg 0, FSM IDLE.
// - Assembly: byte k (k=0..BYTES-1) of a word is written to bits [8k+7:8k]; counter increments
//   per rx_valid; at k=BYTES-1 the word is complete and the counter returns to 0.
// - FSM IDLE (wr_req=0) / PEND (wr_req=1).
//   IDLE -> PEND on word complete: wr_req=1, wr_data=word, wr_adr=next address, in cycle t+1
//   after the completing byte (latency 1).
//   PEND + wr_ack -> next cycle: rx_check+=1, rx_checkh/l latch the word, address+=1 (wraps
//   2**ADRW-1 -> 0), FSM IDLE unless a new word completes in the same cycle as the ack.
//   In that case, load the new word and stay in PEND with no overflow.
//   PEND, no ack, word completes -> word dropped, overflow<=1, rx_check unchanged,
//   pending write untouched; assembly restarts at byte 0.
// - wr_adr/wr_data stable whenever wr_req=1 until the ack cycle.
// - Timeout: timer clears on every rx_valid, counts while counter!=0.
//   Reaching TIMEOUT: the partial word, with remaining bytes zero, completes as a normal word;
//   the counter and timer return to 0.
//   rx_valid in the reaching cycle: the byte is taken, the timer clears, no flush.
//   Flush while PEND and no ack: treated as a drop, overflow<=1.
// - rx_clear (priority over all but reset): next cycle wr_req=0, counter/timer/address/
//   rx_check/overflow=0, FSM IDLE; rx_checkh/l keep values.
//   rx_valid in the same cycle is ignored; wr_ack in the same cycle is ignored.
// - Async reset mid-PEND drops wr_req immediately; no partial state survives.
// - rx_check saturates at 2**32-1.
// TESTING
// - Reset, then 8 bytes 01..08 one per 3 cycles -> wr_req@t+1, wr_data=64'h0807060504030201,
//   wr_adr=0; ack -> rx_check=1, rx_checkh=32'h08070605, rx_checkl=32'h04030201.
// - 3 bytes AA,BB,CC then idle TIMEOUT cycles -> wr_data=64'h0000000000CCBBAA, count+1.
// - Hold wr_ack=0 and send 16 bytes -> first word pending unchanged, overflow=1,
//   rx_check=0 until ack, then 1.
// - Ack in the cycle the next word's 8th byte arrives -> wr_req stays 1, adr 0->1,
//   overflow=0, rx_check=1.
// - ADRW=2: write 5 words -> addresses 0,1,2,3,0; rx_check=5.
// - rx_clear during PEND with 4 partial bytes -> wr_req=0, rx_check=0, next word at adr 0.
// - Assert reset low mid-PEND (asynchronously, off clock edge) -> wr_req=0 immediately,
//   all outputs 0.

Source files
------------

// File: rtl/rx_word_loader_if.sv
// Byte-receive and memory-write bundle for rx_word_loader.
// The slave side is the loader; the master side is the rx source plus memory.
interface rx_word_loader_if #(
  parameter int N    = 64,
  parameter int ADRW = 8
);
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic            rx_clear;
  logic            wr_req;
  logic [ADRW-1:0] wr_adr;
  logic [N-1:0]    wr_data;
  logic            wr_ack;
  logic            overflow;
  logic [31:0]     rx_check;
  logic [31:0]     rx_checkh;
  logic [31:0]     rx_checkl;

  modport slave (
    input  rx_valid, rx_data, rx_clear, wr_ack,
    output wr_req, wr_adr, wr_data, overflow,
    output rx_check, rx_checkh, rx_checkl
  );

  modport master (
    output rx_valid, rx_data, rx_clear, wr_ack,
    input  wr_req, wr_adr, wr_data, overflow,
    input  rx_check, rx_checkh, rx_checkl
  );
endinterface

// File: rtl/rx_word_loader.sv
// Packs rx bytes into little-endian N-bit words and writes them to memory.
// A partial word is zero-padded and flushed after an idle timeout.
module rx_word_loader #(
  parameter int N       = 64,
  parameter int ADRW    = 8,
  parameter int TIMEOUT = 1024
) (
  input logic             clk,
  input logic             reset,
  rx_word_loader_if.slave bus
);
  localparam int BYTES = N / 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int W     = (N > 64) ? N : 64;

  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  typedef enum logic { IDLE, PEND } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  logic [N-1:0]  asm_q;
  logic [N-1:0]  asm_nxt;
  logic [N-1:0]  word;
  logic [W-1:0]  wext;
  logic          last;
  logic          flush;
  logic          done;
  logic          ack;

  always_comb begin
    asm_nxt = asm_q;
    for (int k = 0; k < BYTES; k++) begin
      if (cnt == CW'(k)) asm_nxt[8*k +: 8] = bus.rx_data;
    end
  end

  assign last  = bus.rx_valid && (cnt == LAST);
  assign flush = !bus.rx_valid && (cnt != '0)
                 && (timer == TLIM);
  assign done  = last || flush;
  assign word  = bus.rx_valid ? asm_nxt : asm_q;
  assign ack   = (state == PEND) && bus.wr_ack;
  assign wext  = W'(bus.wr_data);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      timer         <= '0;
      asm_q         <= '0;
      bus.wr_req    <= 1'b0;
      bus.wr_adr    <= '0;
      bus.wr_data   <= '0;
      bus.overflow  <= 1'b0;
      bus.rx_check  <= '0;
      bus.rx_checkh <= '0;
      bus.rx_checkl <= '0;
    end else if (bus.rx_clear) begin
      state        <= IDLE;
      cnt          <= '0;
      timer        <= '0;
      asm_q        <= '0;
      bus.wr_req   <= 1'b0;
      bus.wr_adr   <= '0;
      bus.overflow <= 1'b0;
      bus.rx_check <= '0;
    end else begin
      // assembly register is cleared on completion so padding is zero
      if (bus.rx_valid) begin
        timer <= '0;
        if (last) begin
          cnt   <= '0;
          asm_q <= '0;
        end else begin
          cnt   <= cnt + 1'b1;
          asm_q <= asm_nxt;
        end
      end else if (cnt != '0) begin
        if (timer == TLIM) begin
          cnt   <= '0;
          timer <= '0;
          asm_q <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end

      if (ack) begin
        if (bus.rx_check != '1)
          bus.rx_check <= bus.rx_check + 1'b1;
        bus.rx_checkh <= wext[63:32];
        bus.rx_checkl <= wext[31:0];
        bus.wr_adr    <= bus.wr_adr + 1'b1;
      end

      if (done && (state == IDLE || ack)) begin
        state       <= PEND;
        bus.wr_req  <= 1'b1;
        bus.wr_data <= word;
      end else if (done) begin
        bus.overflow <= 1'b1;
      end else if (ack) begin
        state      <= IDLE;
        bus.wr_req <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rx_word_loader.sv
// Directed bench for rx_word_loader: table rows plus
// hand sequences for timeout, overflow, clear, wrap and reset.
module tb_rx_word_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rx_word_loader_if #(.N(64), .ADRW(8)) b1 ();
  rx_word_loader_if #(.N(64), .ADRW(2)) b2 ();

  rx_word_loader #(.N(64), .ADRW(8), .TIMEOUT(1024)) dut1 (
    .clk(clk), .reset(reset), .bus(b1)
  );

  rx_word_loader #(.N(64), .ADRW(2), .TIMEOUT(16)) dut2 (
    .clk(clk), .reset(reset), .bus(b2)
  );

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        ack;
    logic        req;
    logic [7:0]  adr;
    logic [63:0] data;
    logic [31:0] chk;
    logic        ovf;
    logic [31:0] h;
    logic [31:0] l;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(
    input logic v, input logic [7:0] d,
    input logic ack, input logic req,
    input logic [7:0] adr, input logic [63:0] data,
    input logic [31:0] chk, input logic ovf,
    input logic [31:0] h, input logic [31:0] l
  );
    vec_t r;
    r.v = v; r.d = d; r.ack = ack; r.req = req;
    r.adr = adr; r.data = data; r.chk = chk;
    r.ovf = ovf; r.h = h; r.l = l;
    tbl.push_back(r);
  endfunction

  function automatic logic [63:0] w(input logic [7:0] b);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = b + 8'(k);
    return r;
  endfunction

  task automatic check(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int which, input logic [7:0] d);
    if (which == 1) begin
      b1.rx_valid = 1'b1; b1.rx_data = d;
    end else begin
      b2.rx_valid = 1'b1; b2.rx_data = d;
    end
    tick();
    b1.rx_valid = 1'b0;
    b2.rx_valid = 1'b0;
  endtask

  task automatic send8(input int which, input logic [7:0] b);
    for (int k = 0; k < 8; k++) send(which, b + 8'(k));
  endtask

  task automatic ack(input int which);
    if (which == 1) b1.wr_ack = 1'b1;
    else b2.wr_ack = 1'b1;
    tick();
    b1.wr_ack = 1'b0;
    b2.wr_ack = 1'b0;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!b1.wr_req && n < 2000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    b1.rx_valid = 0; b1.rx_data = 0;
    b1.rx_clear = 0; b1.wr_ack = 0;
    b2.rx_valid = 0; b2.rx_data = 0;
    b2.rx_clear = 0; b2.wr_ack = 0;

    for (int i = 1; i <= 7; i++) begin
      add(1, 8'(i), 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    add(1, 8'h08, 0, 1, 0, w(8'h01), 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, w(8'h01), 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, 1, 0,
        32'h08070605, 32'h04030201);
    for (int i = 0; i < 7; i++)
      add(1, 8'h11 + 8'(i), 0, 0, 1, 0, 1, 0,
          32'h08070605, 32'h04030201);
    add(1, 8'h18, 0, 1, 1, w(8'h11), 1, 0,
        32'h08070605, 32'h04030201);
    for (int i = 0; i < 7; i++)
      add(1, 8'h21 + 8'(i), 0, 1, 1, w(8'h11), 1, 0,
          32'h08070605, 32'h04030201);
    add(1, 8'h28, 1, 1, 2, w(8'h21), 2, 0,
        32'h18171615, 32'h14131211);
    add(0, 0, 1, 0, 3, 0, 3, 0,
        32'h28272625, 32'h24232221);

    repeat (2) tick();
    check("rst req", 64'(b1.wr_req), 0);
    check("rst adr", 64'(b1.wr_adr), 0);
    check("rst data", b1.wr_data, 0);
    check("rst chk", 64'(b1.rx_check), 0);
    check("rst ovf", 64'(b1.overflow), 0);
    check("rst chkh", 64'(b1.rx_checkh), 0);
    check("rst chkl", 64'(b1.rx_checkl), 0);
    reset = 1'b1;
    tick();

    foreach (tbl[i]) begin
      b1.rx_valid = tbl[i].v;
      b1.rx_data  = tbl[i].d;
      b1.wr_ack   = tbl[i].ack;
      tick();
      check($sformatf("row%0d req", i),
            64'(b1.wr_req), 64'(tbl[i].req));
      check($sformatf("row%0d adr", i),
            64'(b1.wr_adr), 64'(tbl[i].adr));
      check($sformatf("row%0d chk", i),
            64'(b1.rx_check), 64'(tbl[i].chk));
      check($sformatf("row%0d ovf", i),
            64'(b1.overflow), 64'(tbl[i].ovf));
      check($sformatf("row%0d chkh", i),
            64'(b1.rx_checkh), 64'(tbl[i].h));
      check($sformatf("row%0d chkl", i),
            64'(b1.rx_checkl), 64'(tbl[i].l));
      if (tbl[i].req)
        check($sformatf("row%0d data", i),
              b1.wr_data, tbl[i].data);
    end
    b1.rx_valid = 0; b1.wr_ack = 0;

    send(1, 8'hAA); send(1, 8'hBB); send(1, 8'hCC);
    wait_req(n);
    check("tmo latency", 64'(n), 1024);
    check("tmo data", b1.wr_data, 64'h0000_0000_00CC_BBAA);
    check("tmo adr", 64'(b1.wr_adr), 3);
    ack(1);
    check("tmo chk", 64'(b1.rx_check), 4);
    check("tmo chkl", 64'(b1.rx_checkl), 32'h00CCBBAA);
    check("tmo req", 64'(b1.wr_req), 0);

    send(1, 8'h01);
    repeat (1023) tick();
    check("edge idle req", 64'(b1.wr_req), 0);
    send(1, 8'h02);
    check("edge take req", 64'(b1.wr_req), 0);
    wait_req(n);
    check("edge latency", 64'(n), 1024);
    check("edge data", b1.wr_data, 64'h0201);
    ack(1);
    check("edge chk", 64'(b1.rx_check), 5);
    check("edge adr", 64'(b1.wr_adr), 5);

    send8(1, 8'h31);
    check("ovf req1", 64'(b1.wr_req), 1);
    send8(1, 8'h39);
    check("ovf flag", 64'(b1.overflow), 1);
    check("ovf data", b1.wr_data, w(8'h31));
    check("ovf adr", 64'(b1.wr_adr), 5);
    check("ovf chk", 64'(b1.rx_check), 5);
    ack(1);
    check("ovf chk ack", 64'(b1.rx_check), 6);
    check("ovf chkl", 64'(b1.rx_checkl), 32'h34333231);
    check("ovf req0", 64'(b1.wr_req), 0);

    send8(1, 8'h51);
    for (int k = 0; k < 4; k++) send(1, 8'h61 + 8'(k));
    check("clr pend", 64'(b1.wr_req), 1);
    b1.rx_clear = 1; b1.rx_valid = 1;
    b1.rx_data = 8'h99; b1.wr_ack = 1;
    tick();
    b1.rx_clear = 0; b1.rx_valid = 0; b1.wr_ack = 0;
    check("clr req", 64'(b1.wr_req), 0);
    check("clr chk", 64'(b1.rx_check), 0);
    check("clr ovf", 64'(b1.overflow), 0);
    check("clr adr", 64'(b1.wr_adr), 0);
    check("clr chkl", 64'(b1.rx_checkl), 32'h34333231);
    send8(1, 8'h71);
    check("clr nreq", 64'(b1.wr_req), 1);
    check("clr ndata", b1.wr_data, w(8'h71));
    check("clr nadr", 64'(b1.wr_adr), 0);
    ack(1);
    check("clr nchk", 64'(b1.rx_check), 1);

    for (int k = 0; k < 5; k++) begin
      send8(2, 8'h80 + 8'(8 * k));
      check($sformatf("wrap req%0d", k),
            64'(b2.wr_req), 1);
      check($sformatf("wrap adr%0d", k),
            64'(b2.wr_adr), 64'(k % 4));
      ack(2);
    end
    check("wrap chk", 64'(b2.rx_check), 5);

    send8(1, 8'h81);
    check("arst pend", 64'(b1.wr_req), 1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("arst req", 64'(b1.wr_req), 0);
    check("arst adr", 64'(b1.wr_adr), 0);
    check("arst data", b1.wr_data, 0);
    check("arst chk", 64'(b1.rx_check), 0);
    check("arst chkh", 64'(b1.rx_checkh), 0);
    check("arst chkl", 64'(b1.rx_checkl), 0);
    check("arst ovf", 64'(b1.overflow), 0);
    tick();
    reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
